// File: rtl/rx_depunc_pkg.sv
// -----------------------------------------------------------------------------
// rx_depunc_pkg
// Shared definitions for the 802.11a receive depuncturer:
//   - code-rate encodings as carried on the rate input
//   - puncture-pattern phase type and last-phase value per rate
//   - neutral soft value inserted at erased positions
//   - helper mapping a rate code to its last phase
// -----------------------------------------------------------------------------
package rx_depunc_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'd0,
    RATE_2_3  = 2'd1,
    RATE_3_4  = 2'd2,
    RATE_RSVD = 2'd3
  } rate_e;

  typedef logic [1:0] phase_t;

  // Last phase of the puncture pattern before wrapping back to 0.
  localparam phase_t PHASE_END_1_2 = 2'd1;
  localparam phase_t PHASE_END_2_3 = 2'd2;
  localparam phase_t PHASE_END_3_4 = 2'd3;

  // Soft value meaning "no information" to the Viterbi branch metric.
  localparam int ERASE_VAL = 0;

  // Reserved rate code falls back to the unpunctured (1/2) pattern.
  function automatic phase_t phase_end_f(input logic [1:0] r);
    case (r)
      RATE_2_3: phase_end_f = PHASE_END_2_3;
      RATE_3_4: phase_end_f = PHASE_END_3_4;
      default:  phase_end_f = PHASE_END_1_2;
    endcase
  endfunction

endpackage

// File: rtl/depunc_phase_ctr.sv
// -----------------------------------------------------------------------------
// depunc_phase_ctr
// Puncture-pattern phase counter with rate-dependent wrap.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_clear        frame_start: phase restarts at 0 this cycle
//   i_adv          a soft bit is accepted this cycle
//   i_last         accepted bit is the frame's last coded bit
//   i_phase_end    last phase of the current pattern
//   o_phase        phase of the bit presented this cycle (0 if i_clear)
// -----------------------------------------------------------------------------
module depunc_phase_ctr
  import rx_depunc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_adv,
  input  logic       i_last,
  input  logic [1:0] i_phase_end,
  output logic [1:0] o_phase
);

  phase_t r_phase;

  // A frame_start bit is processed as phase 0, so the clear is seen combinationally.
  assign o_phase = i_clear ? 2'd0 : r_phase;

  // Phase register: advance on accept, wrap at pattern end or on the frame's last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 2'd0;
    end else if (i_adv) begin
      if (i_last || (o_phase >= i_phase_end)) begin
        r_phase <= 2'd0;
      end else begin
        r_phase <= o_phase + 2'd1;
      end
    end else if (i_clear) begin
      r_phase <= 2'd0;
    end else begin
      r_phase <= r_phase;
    end
  end

endmodule

// File: rtl/rx_depuncture.sv
// -----------------------------------------------------------------------------
// rx_depuncture
// Reinserts the bits stolen by the 802.11a puncturer (rates 2/3, 3/4) and
// emits rate-1/2 (A,B) soft-bit pairs through a one-deep output register.
// Optional build macro: DEPUNC_ERASURE_FLAGS_EN adds out_era_a/out_era_b;
// without it erasures are signalled only by the neutral soft value 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   frame_start, rate         latch rate and restart the pattern
//   in_valid/in_ready/in_bit/in_last   soft coded bit input handshake
//   out_valid/out_ready       output pair handshake
//   out_a, out_b              soft bits for encoder outputs A and B
//   out_era_a, out_era_b      inserted-erasure marks (macro builds only)
//   out_last                  pair carries the frame's final coded bit
// -----------------------------------------------------------------------------
module rx_depuncture
  import rx_depunc_pkg::*;
#(
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [1:0]    rate,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_bit,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_a,
  output logic [SW-1:0] out_b,
`ifdef DEPUNC_ERASURE_FLAGS_EN
  output logic          out_era_a,
  output logic          out_era_b,
`endif
  output logic          out_last
);

  localparam logic [SW-1:0] L_ERASE = SW'(ERASE_VAL);

  logic [1:0]    r_rate;
  logic [SW-1:0] r_hold;
  logic          r_out_valid;
  logic [SW-1:0] r_out_a;
  logic [SW-1:0] r_out_b;
  logic          r_out_last;

  logic          w_accept;
  logic [1:0]    w_rate_eff;
  logic [1:0]    w_phase;
  logic          w_emit;
  logic [SW-1:0] w_a;
  logic [SW-1:0] w_b;
`ifdef DEPUNC_ERASURE_FLAGS_EN
  logic          w_era_a;
  logic          w_era_b;
  logic          r_era_a;
  logic          r_era_b;
`endif

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // A bit arriving with frame_start already uses the new rate.
  assign w_rate_eff = frame_start ? rate : r_rate;

  depunc_phase_ctr u_phase_ctr (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (frame_start),
    .i_adv       (w_accept),
    .i_last      (in_last),
    .i_phase_end (phase_end_f(w_rate_eff)),
    .o_phase     (w_phase)
  );

  // Pair assembly for the accepted bit according to the pattern phase.
  always_comb begin
    w_emit = 1'b0;
    w_a    = L_ERASE;
    w_b    = L_ERASE;
`ifdef DEPUNC_ERASURE_FLAGS_EN
    w_era_a = 1'b0;
    w_era_b = 1'b0;
`endif
    if (w_accept) begin
      case (w_phase)
        2'd0: begin
          // A lone trailing A bit is flushed with B erased.
          if (in_last) begin
            w_emit = 1'b1;
            w_a    = in_bit;
`ifdef DEPUNC_ERASURE_FLAGS_EN
            w_era_b = 1'b1;
`endif
          end else begin
            w_emit = 1'b0;
          end
        end
        2'd1: begin
          w_emit = 1'b1;
          w_a    = r_hold;
          w_b    = in_bit;
        end
        2'd2: begin
          w_emit = 1'b1;
          w_a    = in_bit;
`ifdef DEPUNC_ERASURE_FLAGS_EN
          w_era_b = 1'b1;
`endif
        end
        2'd3: begin
          w_emit = 1'b1;
          w_b    = in_bit;
`ifdef DEPUNC_ERASURE_FLAGS_EN
          w_era_a = 1'b1;
`endif
        end
        default: begin
          w_emit = 1'b0;
        end
      endcase
    end else begin
      w_emit = 1'b0;
    end
  end

  // Rate latch, A-bit hold and the one-deep output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate      <= 2'd0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_last  <= 1'b0;
`ifdef DEPUNC_ERASURE_FLAGS_EN
      r_era_a     <= 1'b0;
      r_era_b     <= 1'b0;
`endif
    end else begin
      if (frame_start) begin
        r_rate <= rate;
      end else begin
        r_rate <= r_rate;
      end

      if (w_accept && (w_phase == 2'd0) && !in_last) begin
        r_hold <= in_bit;
      end else if (frame_start) begin
        r_hold <= '0;
      end else begin
        r_hold <= r_hold;
      end

      // Emission only happens when in_ready, i.e. the register is free or draining.
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_a     <= w_a;
        r_out_b     <= w_b;
        r_out_last  <= in_last;
`ifdef DEPUNC_ERASURE_FLAGS_EN
        r_era_a     <= w_era_a;
        r_era_b     <= w_era_b;
`endif
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_last  = r_out_last;
`ifdef DEPUNC_ERASURE_FLAGS_EN
  assign out_era_a = r_era_a;
  assign out_era_b = r_era_b;
`endif

endmodule

// File: tb/tb_rx_depuncture.sv
// -----------------------------------------------------------------------------
// tb_rx_depuncture
// Directed-vector bench for rx_depuncture with hand-computed expected pairs.
// -----------------------------------------------------------------------------
module tb_rx_depuncture;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [1:0] rate;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_a;
  logic [2:0] out_b;
  logic       out_last;
`ifdef DEPUNC_ERASURE_FLAGS_EN
  logic       out_era_a;
  logic       out_era_b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  int n0;

  always #5 clk = ~clk;

  rx_depuncture #(.SW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .rate        (rate),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bit      (in_bit),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
`ifdef DEPUNC_ERASURE_FLAGS_EN
    .out_era_a   (out_era_a),
    .out_era_b   (out_era_b),
`endif
    .out_last    (out_last)
  );

  // Count output transfers to detect lost or duplicated pairs.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) n_xfer <= n_xfer + 1;
  end

  function automatic logic [2:0] sb(input int v);
    sb = v[2:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input int a, input int b,
                          input logic ea, input logic eb, input logic last);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " a"}, 32'(out_a), 32'(sb(a)));
    chk({tag, " b"}, 32'(out_b), 32'(sb(b)));
    chk({tag, " last"}, 32'(out_last), 32'(last));
`ifdef DEPUNC_ERASURE_FLAGS_EN
    chk({tag, " era_a"}, 32'(out_era_a), 32'(ea));
    chk({tag, " era_b"}, 32'(out_era_b), 32'(eb));
`else
    if (ea || eb) begin
      chk({tag, " erased zero"}, 32'(ea ? out_a : out_b), 32'd0);
    end
`endif
  endtask

  task automatic chk_none(input string tag);
    chk({tag, " no pair"}, 32'(out_valid), 32'd0);
  endtask

  // Present one bit for a single cycle (in_ready assumed high), then sample at #1.
  task automatic bit_in(input int v, input logic last = 1'b0,
                        input logic fs = 1'b0, input logic [1:0] r = 2'd0);
    in_bit      = sb(v);
    in_valid    = 1'b1;
    in_last     = last;
    frame_start = fs;
    rate        = r;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; rate = 2'd0; in_valid = 1'b0;
    in_bit = 3'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_a", 32'(out_a), 32'd0);
    chk("rst out_b", 32'(out_b), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
`ifdef DEPUNC_ERASURE_FLAGS_EN
    chk("rst era_a", 32'(out_era_a), 32'd0);
    chk("rst era_b", 32'(out_era_b), 32'd0);
`endif
    rst = 1'b0;

    // Rate 1/2; final bit at p1 carries last.
    bit_in(3, 1'b0, 1'b1, 2'd0);  chk_none("r12 b0");
    bit_in(-2);                   chk_pair("r12 p0", 3, -2, 1'b0, 1'b0, 1'b0);
    bit_in(1);                    chk_none("r12 b2");
    bit_in(-4, 1'b1);             chk_pair("r12 p1", 1, -4, 1'b0, 1'b0, 1'b1);

    // Rate 2/3 (rate input driven 0 later, must be ignored); wrap keeps next bit as A.
    bit_in(1, 1'b0, 1'b1, 2'd1);  chk_none("r23 b0");
    bit_in(2);                    chk_pair("r23 p0", 1, 2, 1'b0, 1'b0, 1'b0);
    bit_in(3);                    chk_pair("r23 p1", 3, 0, 1'b0, 1'b1, 1'b0);
    bit_in(1);                    chk_none("r23 wrap");
    bit_in(2);                    chk_pair("r23 p2", 1, 2, 1'b0, 1'b0, 1'b0);

    // Rate 3/4.
    bit_in(-1, 1'b0, 1'b1, 2'd2); chk_none("r34 b0");
    bit_in(-2);                   chk_pair("r34 p0", -1, -2, 1'b0, 1'b0, 1'b0);
    bit_in(-3);                   chk_pair("r34 p1", -3, 0, 1'b0, 1'b1, 1'b0);
    bit_in(3);                    chk_pair("r34 p2", 0, 3, 1'b1, 1'b0, 1'b0);
    bit_in(-1);                   chk_none("r34 wrap");

    // frame_start mid-pattern discards the hold and restarts at p0.
    bit_in(1, 1'b0, 1'b1, 2'd1);  chk_none("fs b0");
    bit_in(2, 1'b0, 1'b1, 2'd1);  chk_none("fs restart");
    bit_in(3);                    chk_pair("fs pair", 2, 3, 1'b0, 1'b0, 1'b0);

    // Reserved rate behaves as 1/2.
    bit_in(1, 1'b0, 1'b1, 2'd3);  chk_none("rsv b0");
    bit_in(2);                    chk_pair("rsv p0", 1, 2, 1'b0, 1'b0, 1'b0);
    bit_in(3);                    chk_none("rsv b2");
    bit_in(-1);                   chk_pair("rsv p1", 3, -1, 1'b0, 1'b0, 1'b0);

    // Backpressure at rate 3/4.
    bit_in(1, 1'b0, 1'b1, 2'd2);
    n0 = n_xfer;
    out_ready = 1'b0;
    bit_in(2);                    chk_pair("bp first", 1, 2, 1'b0, 1'b0, 1'b0);
    in_bit = sb(3); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk_pair("bp hold", 1, 2, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_pair("bp release", 3, 0, 1'b0, 1'b1, 1'b0);
    bit_in(-3);                   chk_pair("bp p2", 0, -3, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp xfer count", 32'(n_xfer - n0), 32'd3);
    chk_none("bp drained");

    // in_last at p0, then a fresh frame restarts at p0.
    bit_in(2, 1'b1, 1'b1, 2'd1);  chk_pair("last p0", 2, 0, 1'b0, 1'b1, 1'b1);
    bit_in(1, 1'b0, 1'b1, 2'd1);  chk_none("last restart");
    bit_in(-1);                   chk_pair("last next", 1, -1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame with a pending pair.
    bit_in(1, 1'b0, 1'b1, 2'd2);
    bit_in(2);                    chk_pair("mrst pend", 1, 2, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst out_valid", 32'(out_valid), 32'd0);
    chk("mrst in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    bit_in(3);                    chk_none("mrst phase0");
    bit_in(-1);                   chk_pair("mrst pair", 3, -1, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
